y86_fetch_unit: RTL and testbench

//   Sequential fetch stage for the SEQ Y86-64 core. Holds the architectural PC and fetches one

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_instr_len.sv | 42 ++++
 rtl/y86_fetch_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_y86_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch slice: icode values, status codes,
// the "no register" specifier and the fetch FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [3:0] REG_NONE = 4'hF;

    // Fetch sequence: opcode byte, optional register byte, optional 8 const bytes.
    typedef enum logic [2:0] {
        F_BYTE0 = 3'd0,
        F_REG   = 3'd1,
        F_CONST = 3'd2,
        READY   = 3'd3,
        HALT    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction-shape lookup: icode -> length, register byte
// present, constant present, and whether the icode is a legal instruction.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic [3:0] o_len,
    output logic       o_has_reg,
    output logic       o_has_const,
    output logic       o_valid
);

    // Length table; unknown icodes report invalid with a nominal 1-byte length.
    always_comb begin
        o_len       = 4'd1;
        o_has_reg   = 1'b0;
        o_has_const = 1'b0;
        o_valid     = 1'b1;
        case (i_icode)
            I_HALT, I_NOP, I_RET: begin
                o_len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                o_len     = 4'd2;
                o_has_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                o_len       = 4'd9;
                o_has_const = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                o_len       = 4'd10;
                o_has_reg   = 1'b1;
                o_has_const = 1'b1;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// SEQ Y86-64 fetch stage. Holds the architectural PC and fetches one
// instruction a byte at a time over a req/ack byte memory port, then holds
// the decoded fields until the core retires it with pc_update.
// Optional build macro IFUN_CHECK_EN: also reject illegal ifun values as INS.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] MEM_BYTES = 64'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] next_pc_i,
    input  logic        pc_update,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic [1:0]  stat,
    output logic        halted
);

    fetch_state_t r_state, w_state_next;
    logic [63:0]  r_pc, w_pc_next;
    logic         r_req, w_req_next;
    logic [63:0]  r_addr, w_addr_next;
    logic [3:0]   r_off, w_off_next;     // byte offset of the next fetch from pc
    logic [2:0]   r_cnt, w_cnt_next;     // const byte index
    logic [3:0]   r_icode, w_icode_next;
    logic [3:0]   r_ifun, w_ifun_next;
    logic [3:0]   r_ra, w_ra_next;
    logic [3:0]   r_rb, w_rb_next;
    logic [63:0]  r_valc, w_valc_next;
    logic [63:0]  r_valp, w_valp_next;
    logic         r_valid, w_valid_next;
    logic [1:0]   r_stat, w_stat_next;
    logic         r_halted, w_halted_next;

    logic [3:0]   w_len_icode;
    logic [3:0]   w_len;
    logic         w_has_reg;
    logic         w_has_const;
    logic         w_len_valid;
    logic [63:0]  w_fetch_addr;
    logic         w_addr_fault;
    logic         w_ifun_bad;

    // The opcode byte is decoded straight off the bus on its ack cycle; later
    // bytes use the captured icode.
    assign w_len_icode = (r_state == F_BYTE0) ? imem_rdata[7:4] : r_icode;

    y86_instr_len u_instr_len (
        .i_icode     (w_len_icode),
        .o_len       (w_len),
        .o_has_reg   (w_has_reg),
        .o_has_const (w_has_const),
        .o_valid     (w_len_valid)
    );

    assign w_fetch_addr = r_pc + {60'd0, r_off};
    assign w_addr_fault = (w_fetch_addr >= MEM_BYTES);

`ifdef IFUN_CHECK_EN
    function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
        logic ok;
        case (ic)
            I_OPQ:            ok = (fn <= 4'd3);
            I_JXX, I_RRMOVQ:  ok = (fn <= 4'd6);
            default:          ok = (fn == 4'd0);
        endcase
        return ok;
    endfunction
    assign w_ifun_bad = !ifun_legal(imem_rdata[7:4], imem_rdata[3:0]);
`else
    assign w_ifun_bad = 1'b0;
`endif

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_req_next    = r_req;
        w_addr_next   = r_addr;
        w_off_next    = r_off;
        w_cnt_next    = r_cnt;
        w_icode_next  = r_icode;
        w_ifun_next   = r_ifun;
        w_ra_next     = r_ra;
        w_rb_next     = r_rb;
        w_valc_next   = r_valc;
        w_valp_next   = r_valp;
        w_valid_next  = r_valid;
        w_stat_next   = r_stat;
        w_halted_next = r_halted;
        case (r_state)
            F_BYTE0, F_REG, F_CONST: begin
                if (!r_req) begin
                    // Address range is checked before a request ever leaves.
                    if (w_addr_fault) begin
                        w_stat_next   = STAT_ADR;
                        w_valid_next  = 1'b1;
                        w_halted_next = 1'b1;
                        w_state_next  = READY;
                    end else begin
                        w_req_next  = 1'b1;
                        w_addr_next = w_fetch_addr;
                    end
                end else if (imem_ack) begin
                    w_req_next = 1'b0;
                    w_off_next = r_off + 4'd1;
                    case (r_state)
                        F_BYTE0: begin
                            w_icode_next = imem_rdata[7:4];
                            w_ifun_next  = imem_rdata[3:0];
                            w_valp_next  = r_pc + (w_len_valid ? {60'd0, w_len} : 64'd1);
                            if (!w_len_valid || w_ifun_bad) begin
                                w_stat_next   = STAT_INS;
                                w_valid_next  = 1'b1;
                                w_halted_next = 1'b1;
                                w_state_next  = READY;
                            end else if (imem_rdata[7:4] == I_HALT) begin
                                w_stat_next   = STAT_HLT;
                                w_valid_next  = 1'b1;
                                w_halted_next = 1'b1;
                                w_state_next  = READY;
                            end else if (w_has_reg) begin
                                w_state_next = F_REG;
                            end else if (w_has_const) begin
                                w_cnt_next   = 3'd0;
                                w_state_next = F_CONST;
                            end else begin
                                w_valid_next = 1'b1;
                                w_state_next = READY;
                            end
                        end
                        F_REG: begin
                            w_ra_next = imem_rdata[7:4];
                            w_rb_next = imem_rdata[3:0];
                            if (w_has_const) begin
                                w_cnt_next   = 3'd0;
                                w_state_next = F_CONST;
                            end else begin
                                w_valid_next = 1'b1;
                                w_state_next = READY;
                            end
                        end
                        default: begin
                            w_valc_next[{r_cnt, 3'b000} +: 8] = imem_rdata;
                            w_cnt_next = r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                w_valid_next = 1'b1;
                                w_state_next = READY;
                            end
                        end
                    endcase
                end
            end
            READY: begin
                if (r_stat != STAT_AOK) begin
                    w_state_next = HALT;
                end else if (pc_update) begin
                    w_pc_next    = next_pc_i;
                    w_off_next   = 4'd0;
                    w_cnt_next   = 3'd0;
                    w_icode_next = 4'h0;
                    w_ifun_next  = 4'h0;
                    w_ra_next    = REG_NONE;
                    w_rb_next    = REG_NONE;
                    w_valc_next  = 64'd0;
                    w_valp_next  = 64'd0;
                    w_valid_next = 1'b0;
                    w_stat_next  = STAT_AOK;
                    w_state_next = F_BYTE0;
                end
            end
            default: begin
                // HALT: frozen until reset.
            end
        endcase
    end

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= F_BYTE0;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_off    <= 4'd0;
            r_cnt    <= 3'd0;
            r_icode  <= 4'h0;
            r_ifun   <= 4'h0;
            r_ra     <= REG_NONE;
            r_rb     <= REG_NONE;
            r_valc   <= 64'd0;
            r_valp   <= 64'd0;
            r_valid  <= 1'b0;
            r_stat   <= STAT_AOK;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req    <= w_req_next;
            r_addr   <= w_addr_next;
            r_off    <= w_off_next;
            r_cnt    <= w_cnt_next;
            r_icode  <= w_icode_next;
            r_ifun   <= w_ifun_next;
            r_ra     <= w_ra_next;
            r_rb     <= w_rb_next;
            r_valc   <= w_valc_next;
            r_valp   <= w_valp_next;
            r_valid  <= w_valid_next;
            r_stat   <= w_stat_next;
            r_halted <= w_halted_next;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign pc          = r_pc;
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign rA          = r_ra;
    assign rB          = r_rb;
    assign valC        = r_valc;
    assign valP        = r_valp;
    assign instr_valid = r_valid;
    assign stat        = r_stat;
    assign halted      = r_halted;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed bench for y86_fetch_unit: one instance with the default memory
// size and one with a 16-byte memory for the address-fault case.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] next_pc_a, next_pc_b;
    logic        pc_update_a, pc_update_b;
    logic        imem_ack_a, imem_ack_b;
    logic [7:0]  imem_rdata_a, imem_rdata_b;
    logic        imem_req_a, imem_req_b;
    logic [63:0] imem_addr_a, imem_addr_b;
    logic [63:0] pc_a, pc_b, valC_a, valC_b, valP_a, valP_b;
    logic [3:0]  icode_a, icode_b, ifun_a, ifun_b, rA_a, rA_b, rB_a, rB_b;
    logic        instr_valid_a, instr_valid_b, halted_a, halted_b;
    logic [1:0]  stat_a, stat_b;

    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:255];
    logic [63:0] log_a [$];
    logic [63:0] log_b [$];
    logic [63:0] hold_a;
    logic        addr_moved;
    int          ack_delay, wait_a, wait_b, req_cycles_a;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    y86_fetch_unit dut_a (
        .clk(clk), .rst(rst), .next_pc_i(next_pc_a), .pc_update(pc_update_a),
        .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack_a),
        .imem_rdata(imem_rdata_a), .pc(pc_a), .icode(icode_a), .ifun(ifun_a),
        .rA(rA_a), .rB(rB_a), .valC(valC_a), .valP(valP_a),
        .instr_valid(instr_valid_a), .stat(stat_a), .halted(halted_a)
    );

    y86_fetch_unit #(.RESET_PC(64'h0), .MEM_BYTES(64'd16)) dut_b (
        .clk(clk), .rst(rst), .next_pc_i(next_pc_b), .pc_update(pc_update_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b),
        .imem_rdata(imem_rdata_b), .pc(pc_b), .icode(icode_b), .ifun(ifun_b),
        .rA(rA_b), .rB(rB_b), .valC(valC_b), .valP(valP_b),
        .instr_valid(instr_valid_b), .stat(stat_b), .halted(halted_b)
    );

    // Advance one cycle, then act as the byte memory for both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_req_a) begin
            req_cycles_a++;
            if (wait_a > 0 && imem_addr_a !== hold_a) addr_moved = 1'b1;
            if (wait_a == 0) hold_a = imem_addr_a;
            if (wait_a >= ack_delay) begin
                imem_ack_a   = 1'b1;
                imem_rdata_a = mem_a[imem_addr_a[7:0]];
                log_a.push_back(imem_addr_a);
                $display("[%0t] A ack addr=%h data=%h", $time, imem_addr_a, imem_rdata_a);
                wait_a = 0;
            end else begin
                imem_ack_a = 1'b0;
                wait_a++;
            end
        end else begin
            imem_ack_a = 1'b0;
            wait_a     = 0;
        end
        if (imem_req_b) begin
            imem_ack_b   = 1'b1;
            imem_rdata_b = mem_b[imem_addr_b[7:0]];
            log_b.push_back(imem_addr_b);
            $display("[%0t] B ack addr=%h data=%h", $time, imem_addr_b, imem_rdata_b);
        end else begin
            imem_ack_b = 1'b0;
        end
    endtask

    task automatic wait_valid_a(input int budget);
        for (int i = 0; i < budget && instr_valid_a !== 1'b1; i++) tick();
    endtask

    task automatic wait_valid_b(input int budget);
        for (int i = 0; i < budget && instr_valid_b !== 1'b1; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_update_a = 1'b0;
        pc_update_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_a.delete();
        log_b.delete();
        req_cycles_a = 0;
    endtask

    task automatic load_irmovq();
        logic [79:0] bytes;
        bytes = 80'h30F38877665544332211;
        for (int i = 0; i < 10; i++) mem_a[i] = bytes[79 - 8*i -: 8];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pc_a !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_a, 64'h0); end
        checks++; if (imem_req_a !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_a); end
        checks++; if (instr_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_a); end
        checks++; if (halted_a !== 1'b0 || stat_a !== 2'b00) begin errors++; $display("FAIL reset_stat: got halted=%b stat=%b want 0/00", halted_a, stat_a); end
        checks++; if ({icode_a, ifun_a, rA_a, rB_a} !== 16'h00FF) begin errors++; $display("FAIL reset_fields: got %h want 00ff", {icode_a, ifun_a, rA_a, rB_a}); end
        checks++; if (valC_a !== 64'h0 || valP_a !== 64'h0) begin errors++; $display("FAIL reset_vals: got valC=%h valP=%h want 0/0", valC_a, valP_a); end
        mem_a[0] = 8'h10;
        rst = 1'b0;
        tick();
        checks++; if (imem_req_a !== 1'b1 || imem_addr_a !== 64'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req_a, imem_addr_a); end
    endtask

    task automatic test_irmovq();
        logic seq_ok;
        load_irmovq();
        do_reset();
        wait_valid_a(100);
        checks++; if (instr_valid_a !== 1'b1) begin errors++; $display("FAIL irmovq_valid: got %b want 1", instr_valid_a); end
        checks++; if ({icode_a, ifun_a, rA_a, rB_a} !== 16'h30F3) begin errors++; $display("FAIL irmovq_fields: got %h want 30f3", {icode_a, ifun_a, rA_a, rB_a}); end
        checks++; if (valC_a !== 64'h1122334455667788) begin errors++; $display("FAIL irmovq_valC: got %h want 1122334455667788", valC_a); end
        checks++; if (valP_a !== 64'd10 || stat_a !== 2'b00) begin errors++; $display("FAIL irmovq_valP: got valP=%h stat=%b want a/00", valP_a, stat_a); end
        seq_ok = (log_a.size() == 10);
        for (int i = 0; i < log_a.size(); i++) if (log_a[i] !== 64'(i)) seq_ok = 1'b0;
        checks++; if (seq_ok !== 1'b1) begin errors++; $display("FAIL irmovq_reqs: got %0d requests (in order=%b) want 10 at 0..9", log_a.size(), seq_ok); end
    endtask

    task automatic test_jmp_update();
        logic [63:0] first;
        mem_a[8'h10] = 8'h70;
        mem_a[8'h11] = 8'h40;
        for (int i = 8'h12; i <= 8'h18; i++) mem_a[i] = 8'h00;
        mem_a[8'h40] = 8'h10;
        next_pc_a = 64'h10; pc_update_a = 1'b1; tick(); pc_update_a = 1'b0;
        wait_valid_a(100);
        checks++; if (icode_a !== 4'h7 || valC_a !== 64'h40 || valP_a !== 64'h19 || pc_a !== 64'h10) begin
            errors++; $display("FAIL jmp_decode: got icode=%h valC=%h valP=%h pc=%h want 7/40/19/10", icode_a, valC_a, valP_a, pc_a); end
        log_a.delete();
        next_pc_a = 64'h40; pc_update_a = 1'b1; tick(); pc_update_a = 1'b0;
        checks++; if (pc_a !== 64'h40 || instr_valid_a !== 1'b0) begin errors++; $display("FAIL jmp_update: got pc=%h valid=%b want 40/0", pc_a, instr_valid_a); end
        wait_valid_a(100);
        first = (log_a.size() > 0) ? log_a[0] : '1;
        checks++; if (first !== 64'h40 || valP_a !== 64'h41) begin errors++; $display("FAIL jmp_next_fetch: got addr=%h valP=%h want 40/41", first, valP_a); end
    endtask

    task automatic test_halt();
        mem_a[0] = 8'h00;
        do_reset();
        wait_valid_a(100);
        checks++; if (stat_a !== 2'b01 || valP_a !== 64'd1 || halted_a !== 1'b1) begin
            errors++; $display("FAIL halt_stat: got stat=%b valP=%h halted=%b want 01/1/1", stat_a, valP_a, halted_a); end
        req_cycles_a = 0;
        for (int k = 0; k < 3; k++) begin
            next_pc_a = 64'h80; pc_update_a = 1'b1; tick(); pc_update_a = 1'b0;
            tick(); tick();
        end
        checks++; if (req_cycles_a !== 0 || pc_a !== 64'h0 || halted_a !== 1'b1) begin
            errors++; $display("FAIL halt_frozen: got reqs=%0d pc=%h halted=%b want 0/0/1", req_cycles_a, pc_a, halted_a); end
    endtask

    task automatic test_ins();
        mem_a[0] = 8'hC0;
        do_reset();
        wait_valid_a(100);
        tick(); tick();
        checks++; if (stat_a !== 2'b11 || log_a.size() !== 1 || halted_a !== 1'b1) begin
            errors++; $display("FAIL ins_icode: got stat=%b reqs=%0d halted=%b want 11/1/1", stat_a, log_a.size(), halted_a); end
        mem_a[0] = 8'h67;
        mem_a[1] = 8'h01;
        do_reset();
        wait_valid_a(100);
`ifdef IFUN_CHECK_EN
        checks++; if (stat_a !== 2'b11 || log_a.size() !== 1) begin
            errors++; $display("FAIL ins_ifun: got stat=%b reqs=%0d want 11/1", stat_a, log_a.size()); end
`else
        checks++; if (stat_a !== 2'b00 || {icode_a, ifun_a, rA_a, rB_a} !== 16'h6701 || valP_a !== 64'd2) begin
            errors++; $display("FAIL ifun_pass: got stat=%b fields=%h valP=%h want 00/6701/2", stat_a, {icode_a, ifun_a, rA_a, rB_a}, valP_a); end
`endif
    endtask

    task automatic test_adr();
        logic seq_ok;
        do_reset();
        wait_valid_b(100);
        checks++; if (instr_valid_b !== 1'b1 || stat_b !== 2'b00) begin errors++; $display("FAIL adr_setup: got valid=%b stat=%b want 1/00", instr_valid_b, stat_b); end
        log_b.delete();
        next_pc_b = 64'd12; pc_update_b = 1'b1; tick(); pc_update_b = 1'b0;
        wait_valid_b(100);
        for (int i = 0; i < 10; i++) tick();
        seq_ok = (log_b.size() == 4);
        for (int i = 0; i < log_b.size(); i++) if (log_b[i] !== 64'(12 + i)) seq_ok = 1'b0;
        checks++; if (seq_ok !== 1'b1) begin errors++; $display("FAIL adr_reqs: got %0d requests (in order=%b) want 4 at 12..15", log_b.size(), seq_ok); end
        checks++; if (stat_b !== 2'b10 || halted_b !== 1'b1 || valP_b !== 64'd22) begin
            errors++; $display("FAIL adr_stat: got stat=%b halted=%b valP=%h want 10/1/16", stat_b, halted_b, valP_b); end
    endtask

    task automatic test_delay_reset();
        logic [63:0] first;
        load_irmovq();
        ack_delay = 3;
        do_reset();
        addr_moved = 1'b0;
        wait_valid_a(300);
        checks++; if (addr_moved !== 1'b0 || log_a.size() !== 10) begin errors++; $display("FAIL delay_stable: got moved=%b reqs=%0d want 0/10", addr_moved, log_a.size()); end
        checks++; if (valC_a !== 64'h1122334455667788 || instr_valid_a !== 1'b1) begin errors++; $display("FAIL delay_valC: got %h valid=%b want 1122334455667788/1", valC_a, instr_valid_a); end
        ack_delay = 0;
        do_reset();
        for (int i = 0; i < 100 && log_a.size() < 4; i++) tick();
        ack_delay = 1000;
        tick(); tick(); tick();
        checks++; if (imem_req_a !== 1'b1) begin errors++; $display("FAIL midconst_pending: got req=%b want 1", imem_req_a); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req_a !== 1'b0) begin errors++; $display("FAIL midconst_reqdrop: got req=%b want 0", imem_req_a); end
        rst = 1'b0;
        ack_delay = 0;
        log_a.delete();
        imem_ack_a = 1'b1;
        imem_rdata_a = 8'hC0;
        tick();
        wait_valid_a(100);
        first = (log_a.size() > 0) ? log_a[0] : '1;
        checks++; if (stat_a !== 2'b00 || icode_a !== 4'h3 || first !== 64'h0 || valC_a !== 64'h1122334455667788) begin
            errors++; $display("FAIL late_ack: got stat=%b icode=%h addr=%h valC=%h want 00/3/0/1122334455667788", stat_a, icode_a, first, valC_a); end
    endtask

    initial begin
        rst = 1'b1;
        next_pc_a = '0; next_pc_b = '0;
        pc_update_a = 1'b0; pc_update_b = 1'b0;
        imem_ack_a = 1'b0; imem_ack_b = 1'b0;
        imem_rdata_a = '0; imem_rdata_b = '0;
        ack_delay = 0; wait_a = 0; wait_b = 0; req_cycles_a = 0;
        addr_moved = 1'b0; hold_a = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = 8'h10; mem_b[i] = 8'h10; end
        mem_b[12] = 8'h50; mem_b[13] = 8'h12; mem_b[14] = 8'h08; mem_b[15] = 8'h00;
        test_reset();
        test_irmovq();
        test_jmp_update();
        test_halt();
        test_ins();
        test_adr();
        test_delay_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
